// File: rtl/ls373_bus_arbiter_pkg.sv
// Shared types for the ls373 bus arbiter: FSM state encoding and a sizing helper.
package ls373_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_LATCH, ARB_DRIVE, ARB_TURN} arb_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ls373_bus_arbiter_if.sv
// Requester/latch-bank side signals of the ls373 bus arbiter.
// master = arbiter, slave = requester logic plus latch bank.
interface ls373_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic [N_REQ-1:0] le;
    logic [N_REQ-1:0] oc_b;
    logic [N_REQ-1:0] ack;
    logic             bus_valid;
    logic             busy;

    modport master (input req, output gnt, gnt_id, le, oc_b, ack, bus_valid, busy);
    modport slave  (output req, input gnt, gnt_id, le, oc_b, ack, bus_valid, busy);
endinterface

// File: rtl/ls373_rr_pick.sv
// Combinational winner select: first set req at or after the pointer, wrapping.
// With LS373_ARB_FIXED_PRIO_EN defined the pointer is forced to 0 (lowest index wins).
module ls373_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [IDW-1:0]   o_id
);
    logic [IDW-1:0] w_ptr;

`ifdef LS373_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    assign w_ptr = i_ptr;
`endif

    // Scan from the far end back toward the pointer so the closest match is written last.
    always_comb begin
        int k;
        k     = 0;
        o_win = '0;
        o_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(w_ptr) + i) % N_REQ;
            if (i_req[k]) begin
                o_win    = '0;
                o_win[k] = 1'b1;
                o_id     = IDW'(k);
            end
        end
    end
endmodule

// File: rtl/ls373_bus_arbiter.sv
// Shares one 8-bit bus among N_REQ ls373 latches: LATCH strobe, DRIVE window, TURN gap.
// Optional LS373_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module ls373_bus_arbiter
    import ls373_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    ls373_bus_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(max2(HOLD_CYCLES, TURN_CYCLES) + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 1);

    if (N_REQ < 2)       begin : g_bad_n    $error("N_REQ must be >= 2");       end
    if (HOLD_CYCLES < 1) begin : g_bad_hold $error("HOLD_CYCLES must be >= 1"); end
    if (TURN_CYCLES < 1) begin : g_bad_turn $error("TURN_CYCLES must be >= 1"); end

    arb_state_t       r_state, w_nstate;
    logic [CW-1:0]    r_cnt, w_ncnt;
    logic [N_REQ-1:0] r_win, w_nwin, w_pwin;
    logic [IDW-1:0]   r_id, w_nid, w_pid, w_ptr;

    logic [N_REQ-1:0] r_gnt, r_le, r_ocb, r_ack, w_gnt, w_le, w_ocb, w_ack;
    logic [IDW-1:0]   r_gid, w_gid;
    logic             r_bv, r_busy, w_bv, w_busy;

`ifdef LS373_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_ptr, w_nptr;
    assign w_ptr = r_ptr;

    // LATCH is always left on the next edge, whether to DRIVE or TURN (abort included).
    always_comb begin
        w_nptr = r_ptr;
        if (r_state == ARB_LATCH)
            w_nptr = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= '0;
        else     r_ptr <= w_nptr;
    end
`endif

    ls373_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .i_req (bus.req),
        .i_ptr (w_ptr),
        .o_win (w_pwin),
        .o_id  (w_pid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_win   <= '0;
            r_id    <= '0;
            r_gnt   <= '0;
            r_gid   <= '0;
            r_le    <= '0;
            r_ocb   <= '1;
            r_ack   <= '0;
            r_bv    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_win   <= w_nwin;
            r_id    <= w_nid;
            r_gnt   <= w_gnt;
            r_gid   <= w_gid;
            r_le    <= w_le;
            r_ocb   <= w_ocb;
            r_ack   <= w_ack;
            r_bv    <= w_bv;
            r_busy  <= w_busy;
        end
    end

    // Only the granted index's req is looked at outside IDLE.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nwin   = r_win;
        w_nid    = r_id;
        case (r_state)
            ARB_IDLE: if (|bus.req) begin
                w_nstate = ARB_LATCH;
                w_nwin   = w_pwin;
                w_nid    = w_pid;
            end
            ARB_LATCH: if (bus.req[r_id]) begin
                w_nstate = ARB_DRIVE;
                w_ncnt   = HOLD_LD;
            end else begin
                w_nstate = ARB_TURN;
                w_ncnt   = TURN_LD;
            end
            ARB_DRIVE: if (!bus.req[r_id] || r_cnt == '0) begin
                w_nstate = ARB_TURN;
                w_ncnt   = TURN_LD;
            end else begin
                w_ncnt   = r_cnt - 1'b1;
            end
            ARB_TURN: if (r_cnt == '0) w_nstate = ARB_IDLE;
                      else             w_ncnt   = r_cnt - 1'b1;
            default:  w_nstate = ARB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_gnt  = (w_nstate == ARB_LATCH || w_nstate == ARB_DRIVE) ? w_nwin : '0;
        w_gid  = w_nid;
        w_le   = (w_nstate == ARB_LATCH) ? w_nwin : '0;
        w_ocb  = (w_nstate == ARB_DRIVE) ? ~w_nwin : '1;
        w_ack  = (w_nstate == ARB_DRIVE && w_ncnt == '0) ? w_nwin : '0;
        w_bv   = (w_nstate == ARB_DRIVE);
        w_busy = (w_nstate != ARB_IDLE);
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gid;
    assign bus.le        = r_le;
    assign bus.oc_b      = r_ocb;
    assign bus.ack       = r_ack;
    assign bus.bus_valid = r_bv;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ls373_bus_arbiter.sv
// Directed bench for ls373_bus_arbiter: instance a (HOLD=2, TURN=1), instance b (HOLD=1, TURN=3).
module tb_ls373_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ls373_bus_arbiter_if #(.N_REQ(4)) a ();
    ls373_bus_arbiter_if #(.N_REQ(4)) b ();

    ls373_bus_arbiter #(.N_REQ(4), .HOLD_CYCLES(2), .TURN_CYCLES(1)) dut_a (
        .clk (clk), .rst (rst), .bus (a.master));
    ls373_bus_arbiter #(.N_REQ(4), .HOLD_CYCLES(1), .TURN_CYCLES(3)) dut_b (
        .clk (clk), .rst (rst), .bus (b.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inv(input string tag, input logic [3:0] le, input logic [3:0] ocb,
                       input logic [3:0] ack, inout logic [3:0] last_le, inout logic [3:0] prev_drv);
        logic [3:0] drv;
        logic       ok;
        drv = ~ocb;
        ok  = $onehot0(drv) && $onehot0(le) && ((le & drv) == 4'b0)
              && (ack == 4'b0 || (ack == last_le && ack == drv))
              && !(prev_drv != 4'b0 && drv != 4'b0 && drv != prev_drv);
        chk(tag, {31'b0, ok}, 32'd1);
        if (le != 4'b0) last_le = le;
        prev_drv = drv;
    endtask

    initial begin
        int         order [5];
        int         n;
        logic [3:0] la_le, la_drv, lb_le, lb_drv;
`ifdef LS373_ARB_FIXED_PRIO_EN
        order = '{0, 1, 0, 1, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        a.req = 4'b0;
        b.req = 4'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", a.gnt, 0);
        chk("rst_gid", a.gnt_id, 0);
        chk("rst_le", a.le, 0);
        chk("rst_ocb", a.oc_b, 4'hF);
        chk("rst_ack", a.ack, 0);
        chk("rst_bv", a.bus_valid, 0);
        chk("rst_busy", a.busy, 0);
        rst = 1'b0;

        // single request on index 2
        a.req = 4'b0100;
        step(); chk("t1_le", a.le, 4'b0100); chk("t1_gnt", a.gnt, 4'b0100);
                chk("t1_gid", a.gnt_id, 2); chk("t1_ocb_c1", a.oc_b, 4'hF);
        step(); chk("t1_ocb_c2", a.oc_b, 4'b1011); chk("t1_bv_c2", a.bus_valid, 1);
                chk("t1_le_c2", a.le, 0); chk("t1_ack_c2", a.ack, 0);
        step(); chk("t1_ocb_c3", a.oc_b, 4'b1011); chk("t1_ack_c3", a.ack, 4'b0100);
        a.req = 4'b0;
        step(); chk("t1_ocb_c4", a.oc_b, 4'hF); chk("t1_gnt_c4", a.gnt, 0); chk("t1_busy_c4", a.busy, 1);
        step(); chk("t1_busy_c5", a.busy, 0);

        // abort: index 1 drops in its first DRIVE cycle
        a.req = 4'b0010;
        step(); chk("t3_gid", a.gnt_id, 1);
        step(); chk("t3_drv", a.oc_b, 4'b1101);
        a.req = 4'b0;
        step(); chk("t3_ocb", a.oc_b, 4'hF); chk("t3_ack", a.ack, 0);
                chk("t3_gnt", a.gnt, 0); chk("t3_bv", a.bus_valid, 0); chk("t3_busy", a.busy, 1);
        step(); chk("t3_idle", a.busy, 0);
        a.req = 4'b1001;
`ifdef LS373_ARB_FIXED_PRIO_EN
        step(); chk("t3_ptr_gid", a.gnt_id, 0);
        step(); step(); chk("t3_ack2", a.ack, 4'b0001);
`else
        step(); chk("t3_ptr_gid", a.gnt_id, 3);
        step(); step(); chk("t3_ack2", a.ack, 4'b1000);
`endif
        a.req = 4'b0;
        step(); step(); chk("t3_idle2", a.busy, 0);

        // all requesting, each drops from its ack until the next grant
        a.req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (a.le == 4'b0 && n < 10) begin step(); n++; end
            chk("t2_le_seen", {31'b0, a.le != 4'b0}, 1);
            chk("t2_order", a.gnt_id, order[k]);
            a.req = 4'hF;
            n = 0;
            while (a.ack == 4'b0 && n < 10) begin step(); n++; end
            chk("t2_ack", a.ack, 32'(1) << order[k]);
            a.req = (k == 4) ? 4'b0 : (4'hF & ~(4'b0001 << order[k]));
        end
        step(); step(); chk("t2_idle", a.busy, 0);

        // async reset in the middle of DRIVE
        a.req = 4'b0100;
        step(); step(); chk("t4_pre_bv", a.bus_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_ocb", a.oc_b, 4'hF); chk("t4_le", a.le, 0); chk("t4_gnt", a.gnt, 0);
        chk("t4_busy", a.busy, 0); chk("t4_bv", a.bus_valid, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        a.req = 4'b1001;
        step(); chk("t4_gid", a.gnt_id, 0); chk("t4_le_after", a.le, 4'b0001);
        a.req = 4'b0;
        repeat (3) step();
        chk("t4_idle", a.busy, 0);

        // HOLD=1, TURN=3 instance
        b.req = 4'b1000;
        step(); chk("t6_le", b.le, 4'b1000);
        step(); chk("t6_ocb", b.oc_b, 4'b0111); chk("t6_ack", b.ack, 4'b1000); chk("t6_bv", b.bus_valid, 1);
        b.req = 4'b0;
        step(); chk("t6_turn1", {b.busy, b.oc_b}, 5'h1F);
        step(); chk("t6_turn2", {b.busy, b.oc_b}, 5'h1F);
        step(); chk("t6_turn3", {b.busy, b.oc_b}, 5'h1F);
        step(); chk("t6_idle", b.busy, 0);

        // random traffic with invariant checks on both instances
        la_le = 4'b0; la_drv = 4'b0; lb_le = 4'b0; lb_drv = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            inv("t5_inv_a", a.le, a.oc_b, a.ack, la_le, la_drv);
            inv("t5_inv_b", b.le, b.oc_b, b.ack, lb_le, lb_drv);
            if ($urandom_range(0, 3) == 0) a.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) b.req = 4'($urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
